// File: rtl/rc4_job_sched_pkg.sv
// Shared constants, FSM encoding and small helpers for the RC4 job scheduler.
package rc4_job_sched_pkg;

    localparam int KEY_LEN = 32;
    localparam int MAX_LEN = 1024;
    localparam int TIMEOUT = 4096;
    localparam int LEN_W   = 11;
    localparam int TMO_W   = 13;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_KEY   = 3'd2,
        S_DATA  = 3'd3,
        S_DRAIN = 3'd4,
        S_CLEAR = 3'd5
    } sched_state_e;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_KEY   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_CLEAR = 3'd5;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rc4_job_sched_if.sv
// Host- and core-side signal bundle of the RC4 job scheduler.
interface rc4_job_sched_if;
    import rc4_job_sched_pkg::*;

    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic             mode0;
    logic             mode1;
    logic [1:0]       gnt;
    logic [7:0]       src_data;
    logic             src_valid;
    logic             src_ready;
    logic [1:0]       job_done;
    logic             job_err;
    logic             core_mode;
    logic             core_key_valid;
    logic [7:0]       core_key_in;
    logic             core_data_valid;
    logic [7:0]       core_data_in;
    logic             core_read;
    logic             core_done;
    logic             core_clr;

    // A byte moves exactly in cycles where src_valid && src_ready; src_valid
    // never waits on src_ready, and src_ready may drop without a transfer.
    modport slave (
        input  req, len0, len1, mode0, mode1, src_data, src_valid, core_read, core_done,
        output gnt, src_ready, job_done, job_err, core_mode,
               core_key_valid, core_key_in, core_data_valid, core_data_in, core_clr
    );

    modport master (
        output req, len0, len1, mode0, mode1, src_data, src_valid, core_read, core_done,
        input  gnt, src_ready, job_done, job_err, core_mode,
               core_key_valid, core_key_in, core_data_valid, core_data_in, core_clr
    );

endinterface

// File: rtl/rc4_job_sched_rr_arb2.sv
// Two-input round-robin picker; the last-served pointer moves only on i_upd.
module rc4_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_idx,
    output logic       o_valid,
    output logic       o_idx
);
    logic r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_upd) begin
            r_last <= i_upd_idx;
        end
    end

    // On a tie the requester that was not served last wins.
    always_comb begin
        o_valid = |i_req;
        o_idx   = 1'b0;
        case (i_req)
            2'b01:   o_idx = 1'b0;
            2'b10:   o_idx = 1'b1;
            2'b11:   o_idx = ~r_last;
            default: o_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/rc4_job_sched.sv
// Round-robin job scheduler sharing one RC4 core between two requesters.
// Optional DRAIN watchdog enabled by defining RC4_SCHED_TIMEOUT_EN.
module rc4_job_sched
    import rc4_job_sched_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    rc4_job_sched_if.slave bus,
    output sched_state_e   o_dbg_state
);
    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic             r_winner;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] r_byte_cnt;
    logic [5:0]       r_key_cnt;
    logic             r_core_mode;
    logic             r_key_valid;
    logic             r_data_valid;
    logic [7:0]       r_key_in;
    logic [7:0]       r_data_in;
    logic             w_arb_valid;
    logic             w_arb_idx;
    logic             w_src_ready;
    logic             w_key_xfer;
    logic             w_data_xfer;
    logic             w_bad_len;
    logic             w_core_ok;
    logic             w_timeout;
    logic             w_finish;
    logic             w_done_pulse;

    rc4_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req),
        .i_upd     (w_finish),
        .i_upd_idx (r_winner),
        .o_valid   (w_arb_valid),
        .o_idx     (w_arb_idx)
    );

    assign w_bad_len   = (r_len_q == '0) || (r_len_q > LEN_W'(MAX_LEN));
    assign w_key_xfer  = (r_state == ST_KEY) && bus.src_valid && w_src_ready;
    assign w_data_xfer = (r_state == ST_DATA) && bus.src_valid && w_src_ready;
    assign w_core_ok   = (r_state == ST_DRAIN) && bus.core_done;
    assign w_finish    = w_core_ok || w_timeout;

`ifdef RC4_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // A core_done landing on the expiry cycle still counts as a clean finish.
    assign w_timeout = (r_state == ST_DRAIN) && (r_tmo_cnt == TMO_W'(TIMEOUT)) && !bus.core_done;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_src_ready = 1'b0;
        case (r_state)
            ST_KEY:  w_src_ready = 1'b1;
            ST_DATA: w_src_ready = bus.core_read && (r_byte_cnt < r_len_q);
            default: w_src_ready = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_arb_valid) w_next_state = ST_GRANT;
            ST_GRANT: w_next_state = w_bad_len ? ST_CLEAR : ST_KEY;
            ST_KEY:   if (w_key_xfer && (r_key_cnt == 6'(KEY_LEN - 1))) w_next_state = ST_DATA;
            ST_DATA:  if (w_data_xfer && (r_byte_cnt == r_len_q - LEN_W'(1))) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_finish) w_next_state = ST_CLEAR;
            ST_CLEAR: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Job parameters are captured as the grant is taken so GRANT can judge the length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_winner    <= 1'b0;
            r_len_q     <= '0;
            r_core_mode <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && w_arb_valid) begin
                r_winner    <= w_arb_idx;
                r_len_q     <= w_arb_idx ? bus.len1 : bus.len0;
                r_core_mode <= w_arb_idx ? bus.mode1 : bus.mode0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_key_cnt  <= '0;
            r_byte_cnt <= '0;
        end else begin
            if (w_key_xfer)  r_key_cnt  <= r_key_cnt + 6'd1;
            if (w_data_xfer) r_byte_cnt <= r_byte_cnt + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_valid  <= 1'b0;
            r_key_in     <= '0;
            r_data_valid <= 1'b0;
            r_data_in    <= '0;
        end else begin
            r_key_valid  <= w_key_xfer;
            r_key_in     <= w_key_xfer ? bus.src_data : 8'h00;
            r_data_valid <= w_data_xfer;
            r_data_in    <= w_data_xfer ? bus.src_data : 8'h00;
        end
    end

    assign w_done_pulse = ((r_state == ST_GRANT) && w_bad_len) || w_finish;

    assign bus.gnt             = (r_state != ST_IDLE) ? onehot2(r_winner) : 2'b00;
    assign bus.src_ready       = w_src_ready;
    assign bus.job_done        = w_done_pulse ? onehot2(r_winner) : 2'b00;
    assign bus.job_err         = ((r_state == ST_GRANT) && w_bad_len) || w_timeout;
    assign bus.core_mode       = r_core_mode;
    assign bus.core_key_valid  = r_key_valid;
    assign bus.core_key_in     = r_key_in;
    assign bus.core_data_valid = r_data_valid;
    assign bus.core_data_in    = r_data_in;
    assign bus.core_clr        = (r_state == ST_CLEAR);
    assign o_dbg_state         = sched_state_e'(r_state);

endmodule
